// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM arbiter slice.
// Contents: arbiter FSM state enum, grant-winner enum, default refresh
// timing parameters and the constant command fields driven during a
// CAS-before-RAS refresh slot.
package dram_pkg;

    localparam int ADDR_W             = 23;
    localparam int REFRESH_CYCLES_DEF = 150;
    localparam int MAX_PENDING_DEF    = 4;

    // A refresh slot looks like a read of both bytes to the sequencer.
    localparam logic             REFRESH_RW   = 1'b1;
    localparam logic [1:0]       REFRESH_BE   = 2'b11;
    localparam logic [ADDR_W-1:0] REFRESH_ADDR = 23'h000000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P0   = 2'd1,
        WIN_P1   = 2'd2,
        WIN_REF  = 2'd3
    } winner_t;

endpackage

// File: rtl/dram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the DRAM sequencer.
// Port 0 = 68000 CPU, port 1 = DMA/video fetch.
//   REQn/ADDRn/RWn/BEn : requester command (held until ACKn)
//   ACKn               : one-cycle completion pulse to requester n
//   MEM_*              : command to the sequencer, MEM_DONE back from it
//   REFRESH_OVF        : sticky refresh backlog overflow flag
// slave modport = arbiter view, master modport = environment view.
interface dram_arbiter_if;
    import dram_pkg::*;

    logic              REQ0;
    logic [ADDR_W-1:0] ADDR0;
    logic              RW0;
    logic [1:0]        BE0;
    logic              ACK0;
    logic              REQ1;
    logic [ADDR_W-1:0] ADDR1;
    logic              RW1;
    logic [1:0]        BE1;
    logic              ACK1;
    logic              MEM_REQ;
    logic              MEM_REFRESH;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic              MEM_RW;
    logic [1:0]        MEM_BE;
    logic              MEM_DONE;
    logic              REFRESH_OVF;

    modport slave (
        input  REQ0, ADDR0, RW0, BE0, REQ1, ADDR1, RW1, BE1, MEM_DONE,
        output ACK0, ACK1, MEM_REQ, MEM_REFRESH, MEM_ADDR, MEM_RW, MEM_BE,
               REFRESH_OVF
    );

    modport master (
        output REQ0, ADDR0, RW0, BE0, REQ1, ADDR1, RW1, BE1, MEM_DONE,
        input  ACK0, ACK1, MEM_REQ, MEM_REFRESH, MEM_ADDR, MEM_RW, MEM_BE,
               REFRESH_OVF
    );

endinterface

// File: rtl/dram_refresh_timer.sv
// Refresh scheduler: free-running tick every REFRESH_CYCLES clocks and a
// 3-bit count of refreshes owed to the DRAM.
//   CLK, RST        : clock, synchronous active-low reset
//   refresh_grant_i : arbiter is granting a refresh slot this cycle
//   pending_o       : refreshes owed (0..7)
//   refresh_ovf_o   : sticky, a tick arrived while 7 were already owed
module dram_refresh_timer
    import dram_pkg::*;
#(
    parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       refresh_grant_i,
    output logic [2:0] pending_o,
    output logic       refresh_ovf_o
);

    localparam int               CNT_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pending_q, pending_d;
    logic             ovf_q, ovf_d;
    logic             tick_s;

    // Next-state for the tick counter and the owed-refresh count.
    always_comb begin
        tick_s    = (cnt_q == CNT_LAST);
        cnt_d     = tick_s ? {CNT_W{1'b0}} : (cnt_q + CNT_ONE);
        pending_d = pending_q;
        ovf_d     = ovf_q;
        // A tick and a grant in the same cycle cancel out.
        case ({tick_s, refresh_grant_i})
            2'b10: begin
                if (pending_q == 3'd7) begin
                    ovf_d = 1'b1;
                end else begin
                    pending_d = pending_q + 3'd1;
                end
            end
            2'b01: begin
                if (pending_q != 3'd0) begin
                    pending_d = pending_q - 3'd1;
                end else begin
                    pending_d = pending_q;
                end
            end
            default: pending_d = pending_q;
        endcase
    end

    // State registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q     <= {CNT_W{1'b0}};
            pending_q <= 3'd0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign pending_o     = pending_q;
    assign refresh_ovf_o = ovf_q;

endmodule

// File: rtl/dram_arbiter.sv
// Two-port DRAM arbiter with refresh scheduling.
// Grants the single DRAM sequencer to port 0 (CPU), port 1 (DMA/video) or a
// refresh slot, latches the winning command onto MEM_*, holds it until
// MEM_DONE and then pulses the winner's ACK.
//   CLK, RST : clock, synchronous active-low reset
//   bus      : dram_arbiter_if.slave (requesters, sequencer, REFRESH_OVF)
module dram_arbiter
    import dram_pkg::*;
#(
    parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF,
    parameter int MAX_PENDING    = MAX_PENDING_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    dram_arbiter_if.slave  bus
);

    localparam logic [2:0] MAX_PEND_L = 3'(MAX_PENDING);

    state_t             state_q;
    winner_t            gnt_q;
    winner_t            win_d;
    logic               last_grant_q;
    logic               mem_req_q;
    logic               mem_refresh_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic               mem_rw_q;
    logic [1:0]         mem_be_q;
    logic               ack0_q;
    logic               ack1_q;
    logic [2:0]         pending_s;
    logic               refresh_ovf_s;
    logic               refresh_grant_s;

    dram_refresh_timer #(
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_timer (
        .CLK             (CLK),
        .RST             (RST),
        .refresh_grant_i (refresh_grant_s),
        .pending_o       (pending_s),
        .refresh_ovf_o   (refresh_ovf_s)
    );

    // Winner selection: a large refresh backlog beats everything, ports
    // alternate on a tie, and refresh otherwise only fills idle slots.
    always_comb begin
        win_d = WIN_NONE;
        if (pending_s >= MAX_PEND_L) begin
            win_d = WIN_REF;
        end else if (bus.REQ0 && bus.REQ1) begin
            win_d = last_grant_q ? WIN_P0 : WIN_P1;
        end else if (bus.REQ0) begin
            win_d = WIN_P0;
        end else if (bus.REQ1) begin
            win_d = WIN_P1;
        end else if (pending_s != 3'd0) begin
            win_d = WIN_REF;
        end else begin
            win_d = WIN_NONE;
        end
        refresh_grant_s = (state_q == IDLE) && (win_d == WIN_REF);
    end

    // Arbiter FSM with registered command and acknowledge outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q       <= IDLE;
            gnt_q         <= WIN_NONE;
            last_grant_q  <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_refresh_q <= 1'b0;
            mem_addr_q    <= {ADDR_W{1'b0}};
            mem_rw_q      <= 1'b1;
            mem_be_q      <= 2'b00;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_d != WIN_NONE) begin
                        gnt_q   <= win_d;
                        state_q <= ISSUE;
                        case (win_d)
                            WIN_P0: begin
                                mem_refresh_q <= 1'b0;
                                mem_addr_q    <= bus.ADDR0;
                                mem_rw_q      <= bus.RW0;
                                mem_be_q      <= bus.BE0;
                                last_grant_q  <= 1'b0;
                            end
                            WIN_P1: begin
                                mem_refresh_q <= 1'b0;
                                mem_addr_q    <= bus.ADDR1;
                                mem_rw_q      <= bus.RW1;
                                mem_be_q      <= bus.BE1;
                                last_grant_q  <= 1'b1;
                            end
                            default: begin
                                mem_refresh_q <= 1'b1;
                                mem_addr_q    <= REFRESH_ADDR;
                                mem_rw_q      <= REFRESH_RW;
                                mem_be_q      <= REFRESH_BE;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    mem_req_q <= 1'b1;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    // Requests are not looked at here; only completion matters.
                    if (bus.MEM_DONE) begin
                        mem_req_q <= 1'b0;
                        ack0_q    <= (gnt_q == WIN_P0);
                        ack1_q    <= (gnt_q == WIN_P1);
                        state_q   <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Dead cycle so the acked requester can drop REQ first.
                    state_q <= IDLE;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ACK0        = ack0_q;
    assign bus.ACK1        = ack1_q;
    assign bus.MEM_REQ     = mem_req_q;
    assign bus.MEM_REFRESH = mem_refresh_q;
    assign bus.MEM_ADDR    = mem_addr_q;
    assign bus.MEM_RW      = mem_rw_q;
    assign bus.MEM_BE      = mem_be_q;
    assign bus.REFRESH_OVF = refresh_ovf_s;

endmodule
